// File: rtl/disp_arbiter_if.sv
// Display bus bundle between the data producers and the arbiter that drives `display`.
// Producer side is master; the arbiter is slave.
interface disp_arbiter_if;
  logic [15:0] base_data;
  logic        req0;
  logic [15:0] ovl0_data;
  logic        req1;
  logic [15:0] ovl1_data;
  logic        blink_req;
  logic [15:0] data;
  logic [3:0]  digit_on;
  logic [1:0]  owner;
  logic        busy;

  modport master (
    output base_data, req0, ovl0_data, req1, ovl1_data, blink_req,
    input  data, digit_on, owner, busy
  );

  modport slave (
    input  base_data, req0, ovl0_data, req1, ovl1_data, blink_req,
    output data, digit_on, owner, busy
  );
endinterface

// File: rtl/disp_arbiter.sv
// Shares the display bus between a background value and two timed overlays (1 beats 0), and blinks the background.
// All outputs registered (state to output 1 cycle, base_data to data 1 cycle); requests are strobes, no backpressure.
module disp_arbiter #(
  parameter int unsigned HOLD_TICKS  = 75_000_000,
  parameter int unsigned BLINK_TICKS = 12_500_000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  disp_arbiter_if.slave bus
);

  localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_BASE  = 2'd0,
    ST_SHOW0 = 2'd1,
    ST_SHOW1 = 2'd2
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic [15:0]   r_lat0;
  logic [15:0]   r_lat1;
  logic          r_pend;
  logic [BW-1:0] r_bcnt;
  logic          r_blit;
  logic [15:0]   r_data;
  logic [3:0]    r_digit;
  logic [1:0]    r_owner;
  logic          r_busy;

  state_t        w_nxt_state;
  logic [HW-1:0] w_nxt_hold;
  logic [15:0]   w_nxt_lat0;
  logic [15:0]   w_nxt_lat1;
  logic          w_nxt_pend;
  logic [BW-1:0] w_nxt_bcnt;
  logic          w_nxt_blit;
  logic [15:0]   w_nxt_data;
  logic [3:0]    w_nxt_digit;
  logic [1:0]    w_nxt_owner;
  logic          w_nxt_busy;
  logic          w_expired;
  logic          w_to_base;

  assign w_expired = (r_hold == '0);

  // Requests take priority over expiry: a strobe in the last cycle acts as if the overlay were still up.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold;
    w_nxt_lat0  = r_lat0;
    w_nxt_lat1  = r_lat1;
    w_nxt_pend  = r_pend;
    case (r_state)
      ST_BASE: begin
        if (bus.req1) begin
          w_nxt_state = ST_SHOW1;
          w_nxt_hold  = HOLD_LOAD;
          w_nxt_lat1  = bus.ovl1_data;
          if (bus.req0) begin
            w_nxt_lat0 = bus.ovl0_data;
            w_nxt_pend = 1'b1;
          end
        end else if (bus.req0) begin
          w_nxt_state = ST_SHOW0;
          w_nxt_hold  = HOLD_LOAD;
          w_nxt_lat0  = bus.ovl0_data;
        end
      end
      ST_SHOW0: begin
        if (bus.req1) begin
          w_nxt_state = ST_SHOW1;
          w_nxt_hold  = HOLD_LOAD;
          w_nxt_lat1  = bus.ovl1_data;
          if (bus.req0) begin
            w_nxt_lat0 = bus.ovl0_data;
            w_nxt_pend = 1'b1;
          end
        end else if (bus.req0) begin
          w_nxt_hold = HOLD_LOAD;
          w_nxt_lat0 = bus.ovl0_data;
        end else if (w_expired) begin
          w_nxt_state = ST_BASE;
        end else begin
          w_nxt_hold = r_hold - 1'b1;
        end
      end
      ST_SHOW1: begin
        if (bus.req1) begin
          w_nxt_hold = HOLD_LOAD;
          w_nxt_lat1 = bus.ovl1_data;
          if (bus.req0) begin
            w_nxt_lat0 = bus.ovl0_data;
            w_nxt_pend = 1'b1;
          end
        end else if (w_expired) begin
          if (bus.req0 || r_pend) begin
            w_nxt_state = ST_SHOW0;
            w_nxt_hold  = HOLD_LOAD;
            w_nxt_pend  = 1'b0;
            if (bus.req0) begin
              w_nxt_lat0 = bus.ovl0_data;
            end
          end else begin
            w_nxt_state = ST_BASE;
          end
        end else begin
          w_nxt_hold = r_hold - 1'b1;
          if (bus.req0) begin
            w_nxt_lat0 = bus.ovl0_data;
            w_nxt_pend = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = ST_BASE;
      end
    endcase
  end

  assign w_to_base = (r_state != ST_BASE) && (w_nxt_state == ST_BASE);

  // Holding the phase at "lit, 0" while blink_req is low makes the rising edge start lit for free.
  always_comb begin
    w_nxt_bcnt = r_bcnt;
    w_nxt_blit = r_blit;
    if (!bus.blink_req || w_to_base) begin
      w_nxt_bcnt = '0;
      w_nxt_blit = 1'b1;
    end else if (r_bcnt == BLINK_LAST) begin
      w_nxt_bcnt = '0;
      w_nxt_blit = ~r_blit;
    end else begin
      w_nxt_bcnt = r_bcnt + 1'b1;
    end
  end

  always_comb begin
    w_nxt_data  = '0;
    w_nxt_owner = 2'd0;
    case (r_state)
      ST_BASE: begin
        w_nxt_data  = bus.base_data;
        w_nxt_owner = 2'd0;
      end
      ST_SHOW0: begin
        w_nxt_data  = r_lat0;
        w_nxt_owner = 2'd1;
      end
      ST_SHOW1: begin
        w_nxt_data  = r_lat1;
        w_nxt_owner = 2'd2;
      end
      default: begin
        w_nxt_data  = '0;
        w_nxt_owner = 2'd0;
      end
    endcase
    w_nxt_busy  = (r_state != ST_BASE);
    w_nxt_digit = (r_state == ST_BASE && bus.blink_req && !r_blit) ? 4'h0 : 4'hF;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_BASE;
      r_hold  <= '0;
      r_lat0  <= '0;
      r_lat1  <= '0;
      r_pend  <= 1'b0;
      r_bcnt  <= '0;
      r_blit  <= 1'b1;
      r_data  <= '0;
      r_digit <= 4'hF;
      r_owner <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_hold  <= w_nxt_hold;
      r_lat0  <= w_nxt_lat0;
      r_lat1  <= w_nxt_lat1;
      r_pend  <= w_nxt_pend;
      r_bcnt  <= w_nxt_bcnt;
      r_blit  <= w_nxt_blit;
      r_data  <= w_nxt_data;
      r_digit <= w_nxt_digit;
      r_owner <= w_nxt_owner;
      r_busy  <= w_nxt_busy;
    end
  end

  assign bus.data     = r_data;
  assign bus.digit_on = r_digit;
  assign bus.owner    = r_owner;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed vector table, hand-written blink/reset sequences, then random traffic vs a timeline model.
module tb_disp_arbiter;
  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  logic clk = 1'b0;
  logic rst_n;
  disp_arbiter_if bus();

  disp_arbiter #(.HOLD_TICKS(HOLD), .BLINK_TICKS(BLINK)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic        rst_n;
    logic        req0;
    logic [15:0] d0;
    logic        req1;
    logic [15:0] d1;
    logic [15:0] base;
    logic        blink;
    logic [15:0] e_data;
    logic [1:0]  e_owner;
    logic [3:0]  e_digit;
  } vec_t;
  vec_t vecs[$];

  // Timeline model: who owns the screen, the edge on which that ends, and the edge blink phase 0 falls on.
  int          m_n = 0;
  int          m_cur = 0;
  int          m_end = 0;
  int          m_bstart = 0;
  bit          m_pend = 0;
  logic [15:0] m_v0 = '0;
  logic [15:0] m_v1 = '0;
  logic [15:0] m_data;
  logic [1:0]  m_owner;
  logic [3:0]  m_digit;

  function automatic void grant(input int who);
    m_cur = who;
    m_end = m_n + HOLD;
  endfunction

  function automatic void model_edge();
    bit expired;
    m_n++;
    if (!rst_n) begin
      m_data = '0; m_owner = 2'd0; m_digit = 4'hF;
      m_cur = 0; m_pend = 0; m_v0 = '0; m_v1 = '0; m_bstart = m_n + 1;
      return;
    end
    m_data  = (m_cur == 0) ? bus.base_data : ((m_cur == 1) ? m_v0 : m_v1);
    m_owner = 2'(m_cur);
    m_digit = (m_cur == 0 && bus.blink_req && (((m_n - m_bstart) / BLINK) % 2) == 1) ? 4'h0 : 4'hF;
    expired = (m_cur != 0) && (m_n == m_end);
    if (bus.req1) begin
      grant(2);
      m_v1 = bus.ovl1_data;
      if (bus.req0) begin m_v0 = bus.ovl0_data; m_pend = 1; end
    end else if (bus.req0) begin
      m_v0 = bus.ovl0_data;
      if (m_cur == 2) begin
        if (expired) begin grant(1); m_pend = 0; end
        else m_pend = 1;
      end else begin
        grant(1);
      end
    end else if (expired) begin
      if (m_cur == 2 && m_pend) begin
        grant(1);
        m_pend = 0;
      end else begin
        m_cur = 0;
        m_bstart = m_n + 1;
      end
    end
    if (!bus.blink_req) m_bstart = m_n + 1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ed, input logic [1:0] eo, input logic [3:0] eg);
    chk({tag, ".data"},     bus.data,            ed);
    chk({tag, ".owner"},    16'(bus.owner),      16'(eo));
    chk({tag, ".busy"},     16'(bus.busy),       16'(eo != 2'd0));
    chk({tag, ".digit_on"}, 16'(bus.digit_on),   16'(eg));
  endtask

  task automatic drive(input logic rs, input logic r0, input logic [15:0] d0, input logic r1,
                       input logic [15:0] d1, input logic [15:0] base, input logic bl);
    rst_n = rs; bus.req0 = r0; bus.ovl0_data = d0; bus.req1 = r1; bus.ovl1_data = d1;
    bus.base_data = base; bus.blink_req = bl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic void rep(input int n, input logic rs, input logic r0, input logic [15:0] d0,
                              input logic r1, input logic [15:0] d1, input logic [15:0] base,
                              input logic [15:0] ed, input logic [1:0] eo);
    vec_t v;
    v.rst_n = rs; v.req0 = r0; v.d0 = d0; v.req1 = r1; v.d1 = d1; v.base = base; v.blink = 1'b0;
    v.e_data = ed; v.e_owner = eo; v.e_digit = 4'hF;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] b;
    b = 16'h1234;
    rep(1, 0, 0, 0,        0, 0,        b, 16'h0000, 0);
    rep(1, 1, 0, 0,        0, 0,        b, b,        0);
    rep(1, 1, 1, 16'hA5A5, 0, 0,        b, b,        0);
    rep(8, 1, 0, 0,        0, 0,        b, 16'hA5A5, 1);
    rep(1, 1, 0, 0,        0, 0,        b, b,        0);
    // restart: second req0 at cycle 5 keeps overlay up through cycle 13
    rep(1, 1, 1, 16'hA5A5, 0, 0,        b, b,        0);
    rep(4, 1, 0, 0,        0, 0,        b, 16'hA5A5, 1);
    rep(1, 1, 1, 16'h5A5A, 0, 0,        b, 16'hA5A5, 1);
    rep(8, 1, 0, 0,        0, 0,        b, 16'h5A5A, 1);
    rep(1, 1, 0, 0,        0, 0,        b, b,        0);
    rep(1, 1, 1, 16'h0001, 1, 16'h0002, b, b,        0);
    rep(8, 1, 0, 0,        0, 0,        b, 16'h0002, 2);
    rep(8, 1, 0, 0,        0, 0,        b, 16'h0001, 1);
    rep(1, 1, 0, 0,        0, 0,        b, b,        0);
    rep(1, 1, 1, 16'hBEEF, 0, 0,        b, b,        0);
    rep(2, 1, 0, 0,        0, 0,        b, 16'hBEEF, 1);
    rep(1, 1, 0, 0,        1, 16'hC0DE, b, 16'hBEEF, 1);
    rep(8, 1, 0, 0,        0, 0,        b, 16'hC0DE, 2);
    rep(3, 1, 0, 0,        0, 0,        16'h4321, 16'h4321, 0);

    drive(0, 0, 0, 0, 0, b, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].req0, vecs[i].d0, vecs[i].req1, vecs[i].d1, vecs[i].base, vecs[i].blink);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_owner, vecs[i].e_digit);
    end

    // Blink from the rise, a req1 mid-blink, then blink restarting lit.
    drive(1, 0, 0, 0, 0, b, 1);
    for (int i = 0; i < 10; i++) begin
      tick(); chk_out($sformatf("blink_a%0d", i), b, 0, ((i / BLINK) % 2) ? 4'h0 : 4'hF);
    end
    drive(1, 0, 0, 1, 16'h7777, b, 1);
    tick(); chk_out("blink_req1", b, 0, 4'hF);
    drive(1, 0, 0, 0, 0, b, 1);
    for (int i = 0; i < HOLD; i++) begin
      tick(); chk_out($sformatf("blink_ovl%0d", i), 16'h7777, 2, 4'hF);
    end
    for (int i = 0; i < 10; i++) begin
      tick(); chk_out($sformatf("blink_b%0d", i), b, 0, ((i / BLINK) % 2) ? 4'h0 : 4'hF);
    end
    drive(1, 0, 0, 0, 0, b, 0);
    tick(); chk_out("blink_off", b, 0, 4'hF);

    // Reset during SHOW1 with overlay 0 pending.
    drive(1, 1, 16'h1111, 1, 16'h2222, b, 1);
    tick(); chk_out("rs_req", b, 0, 4'hF);
    drive(1, 0, 0, 0, 0, b, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("rs_show%0d", i), 16'h2222, 2, 4'hF);
    end
    drive(0, 1, 16'h9999, 1, 16'h8888, b, 1);
    tick(); chk_out("rs_reset", 16'h0000, 0, 4'hF);
    drive(1, 0, 0, 0, 0, 16'hABCD, 0);
    tick(); chk_out("rs_release", 16'hABCD, 0, 4'hF);
    drive(1, 1, 16'h4242, 0, 0, 16'hABCD, 0);
    tick(); chk_out("rs_req0", 16'hABCD, 0, 4'hF);
    drive(1, 0, 0, 0, 0, 16'hABCD, 0);
    for (int i = 0; i < HOLD; i++) begin
      tick(); chk_out($sformatf("rs_ovl0_%0d", i), 16'h4242, 1, 4'hF);
    end
    tick(); chk_out("rs_back", 16'hABCD, 0, 4'hF);
    drive(1, 0, 0, 1, 16'h5555, 16'hABCD, 0);
    tick(); chk_out("rs_req1", 16'hABCD, 0, 4'hF);
    drive(1, 0, 0, 0, 0, 16'hABCD, 0);
    for (int i = 0; i < HOLD; i++) begin
      tick(); chk_out($sformatf("rs_ovl1_%0d", i), 16'h5555, 2, 4'hF);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); chk_out($sformatf("rs_nopend%0d", i), 16'hABCD, 0, 4'hF);
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.req0      = ($urandom_range(0, 9) == 0);
      bus.req1      = ($urandom_range(0, 13) == 0);
      bus.ovl0_data = 16'($urandom);
      bus.ovl1_data = 16'($urandom);
      bus.base_data = 16'($urandom);
      if ($urandom_range(0, 39) == 0) bus.blink_req = ~bus.blink_req;
      tick();
      chk("rnd.data",     bus.data,          m_data);
      chk("rnd.owner",    16'(bus.owner),    16'(m_owner));
      chk("rnd.busy",     16'(bus.busy),     16'(m_owner != 2'd0));
      chk("rnd.digit_on", 16'(bus.digit_on), 16'(m_digit));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
